// File: rtl/mac_stop_mem_stream_if.sv
// mac_stop_mem_stream_if
// Groups the data-path ports of mac_stop_mem_stream so that they travel as
// one bundle.
//   A port : a_we, a_re, a_row, a_col, a_wdata -> a_rdata, a_rvalid
//   B port : b_we, b_re, b_row, b_col, b_wdata -> b_rdata, b_rvalid
//   C port : c_we, c_re, c_acc, c_row, c_col, c_wdata -> c_rdata, c_rvalid
//   Loader : ld_start, ld_sel, ld_valid, ld_data -> ld_ready, ld_done
//   Clear  : clr_start -> clr_busy
//   Status : err (sticky conflict flag)
// The slave modport is used by the memory block. The master modport is used
// by whoever drives it.
interface mac_stop_mem_stream_if #(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
);
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = DATA_WIDTH_INIT_MATRIX;
  localparam int R  = DATA_WIDTH_RESULT_MATRIX;

  logic          a_we, a_re;
  logic [MW-1:0] a_row;
  logic [KW-1:0] a_col;
  logic [W-1:0]  a_wdata, a_rdata;
  logic          a_rvalid;

  logic          b_we, b_re;
  logic [KW-1:0] b_row;
  logic [NW-1:0] b_col;
  logic [W-1:0]  b_wdata, b_rdata;
  logic          b_rvalid;

  logic          c_we, c_re, c_acc;
  logic [MW-1:0] c_row;
  logic [NW-1:0] c_col;
  logic [R-1:0]  c_wdata, c_rdata;
  logic          c_rvalid;

  logic          ld_start, ld_sel, ld_valid;
  logic [W-1:0]  ld_data;
  logic          ld_ready, ld_done;

  logic          clr_start, clr_busy;
  logic          err;

  modport slave (
    input  a_we, a_re, a_row, a_col, a_wdata,
    output a_rdata, a_rvalid,
    input  b_we, b_re, b_row, b_col, b_wdata,
    output b_rdata, b_rvalid,
    input  c_we, c_re, c_acc, c_row, c_col, c_wdata,
    output c_rdata, c_rvalid,
    input  ld_start, ld_sel, ld_valid, ld_data,
    output ld_ready, ld_done,
    input  clr_start,
    output clr_busy,
    output err
  );

  modport master (
    output a_we, a_re, a_row, a_col, a_wdata,
    input  a_rdata, a_rvalid,
    output b_we, b_re, b_row, b_col, b_wdata,
    input  b_rdata, b_rvalid,
    output c_we, c_re, c_acc, c_row, c_col, c_wdata,
    input  c_rdata, c_rvalid,
    output ld_start, ld_sel, ld_valid, ld_data,
    input  ld_ready, ld_done,
    output clr_start,
    input  clr_busy,
    input  err
  );
endinterface

// File: rtl/mac_stop_mem_stream.sv
// mac_stop_mem_stream
// This block holds the operand matrices A (MxK) and B (KxN) and the result
// matrix C (MxN). Each matrix has a random-access port with a registered
// read. A stream loader fills A or B in row-major order. A clear engine
// zeroes C. When an engine and a random write collide, the engine write is
// kept and the sticky err flag is set.
// Ports:
//   clk   : the only clock. All logic uses its rising edge.
//   reset : synchronous, active-high. It zeroes all storage and all outputs.
//   bus   : mac_stop_mem_stream_if.slave. It carries the A/B/C ports, the
//           loader, the clear engine and err.
// Optional feature: define MAC_STOP_MEM_FWD_EN to enable write-to-read
// forwarding. With it, a read of the element written in the same cycle
// returns the new value. Without it, the read returns the old value.
module mac_stop_mem_stream #(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
  input logic clk,
  input logic reset,
  mac_stop_mem_stream_if.slave bus
);
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (MW > KW) ? MW : KW;
  localparam int CW = (KW > NW) ? KW : NW;
  localparam int W  = DATA_WIDTH_INIT_MATRIX;
  localparam int R  = DATA_WIDTH_RESULT_MATRIX;

`ifdef MAC_STOP_MEM_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic {L_IDLE, L_RUN} ld_state_t;
  typedef enum logic {C_IDLE, C_RUN} clr_state_t;

  logic [W-1:0] a_mem [M][K];
  logic [W-1:0] b_mem [K][N];
  logic [R-1:0] c_mem [M][N];

  ld_state_t     ld_state;
  logic          ld_sel_q;
  logic [RW-1:0] ld_row, ld_row_max;
  logic [CW-1:0] ld_col, ld_col_max;
  logic          ld_run, ld_beat, ld_last;

  clr_state_t    clr_state;
  logic [MW-1:0] clr_row;
  logic [NW-1:0] clr_col;
  logic          clr_run, clr_last;

  assign ld_run     = (ld_state == L_RUN);
  assign ld_beat    = ld_run && bus.ld_valid;
  // The geometry of the load depends on the matrix that was latched at start.
  assign ld_row_max = ld_sel_q ? RW'(K - 1) : RW'(M - 1);
  assign ld_col_max = ld_sel_q ? CW'(N - 1) : CW'(K - 1);
  assign ld_last    = (ld_row == ld_row_max) && (ld_col == ld_col_max);
  assign clr_run    = (clr_state == C_RUN);
  assign clr_last   = (clr_row == MW'(M - 1)) && (clr_col == NW'(N - 1));

  // A random write is locked out for the whole load of its matrix. This
  // holds even in cycles with no beat.
  logic a_locked, b_locked;
  assign a_locked = ld_run && !ld_sel_q;
  assign b_locked = ld_run && ld_sel_q;

  // Each matrix has one effective write port per cycle. An engine write,
  // when present, takes priority over a random write. A random write that
  // conflicts is dropped. Forwarding uses these same signals, so a read sees
  // exactly what is stored.
  logic          a_wen, b_wen, c_wen;
  logic [MW-1:0] a_wr, c_wr;
  logic [KW-1:0] a_wc, b_wr;
  logic [NW-1:0] b_wc, c_wc;
  logic [W-1:0]  a_wd, b_wd;
  logic [R-1:0]  c_wd;

  always_comb begin
    a_wen = 1'b0;
    a_wr  = bus.a_row;
    a_wc  = bus.a_col;
    a_wd  = bus.a_wdata;
    if (ld_beat && !ld_sel_q) begin
      a_wen = 1'b1;
      a_wr  = ld_row[MW-1:0];
      a_wc  = ld_col[KW-1:0];
      a_wd  = bus.ld_data;
    end else if (bus.a_we && !a_locked) begin
      a_wen = 1'b1;
    end
  end

  always_comb begin
    b_wen = 1'b0;
    b_wr  = bus.b_row;
    b_wc  = bus.b_col;
    b_wd  = bus.b_wdata;
    if (ld_beat && ld_sel_q) begin
      b_wen = 1'b1;
      b_wr  = ld_row[KW-1:0];
      b_wc  = ld_col[NW-1:0];
      b_wd  = bus.ld_data;
    end else if (bus.b_we && !b_locked) begin
      b_wen = 1'b1;
    end
  end

  // An accumulate adds to the stored element and wraps modulo 2^R.
  always_comb begin
    c_wen = 1'b0;
    c_wr  = bus.c_row;
    c_wc  = bus.c_col;
    c_wd  = bus.c_acc ? (c_mem[bus.c_row][bus.c_col] + bus.c_wdata) : bus.c_wdata;
    if (clr_run) begin
      c_wen = 1'b1;
      c_wr  = clr_row;
      c_wc  = clr_col;
      c_wd  = '0;
    end else if (bus.c_we) begin
      c_wen = 1'b1;
    end
  end

  logic a_fwd, b_fwd, c_fwd;
  assign a_fwd = FWD_EN && a_wen && (a_wr == bus.a_row) && (a_wc == bus.a_col);
  assign b_fwd = FWD_EN && b_wen && (b_wr == bus.b_row) && (b_wc == bus.b_col);
  assign c_fwd = FWD_EN && c_wen && (c_wr == bus.c_row) && (c_wc == bus.c_col);

  // Storage arrays. Reset clears every element.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < K; c++)
          a_mem[r][c] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < N; c++)
          b_mem[r][c] <= '0;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          c_mem[r][c] <= '0;
    end else begin
      if (a_wen) a_mem[a_wr][a_wc] <= a_wd;
      if (b_wen) b_mem[b_wr][b_wc] <= b_wd;
      if (c_wen) c_mem[c_wr][c_wc] <= c_wd;
    end
  end

  // Registered read ports. rdata keeps its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
      bus.c_rdata  <= '0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.c_rvalid <= 1'b0;
    end else begin
      bus.a_rvalid <= bus.a_re;
      bus.b_rvalid <= bus.b_re;
      bus.c_rvalid <= bus.c_re;
      if (bus.a_re) bus.a_rdata <= a_fwd ? a_wd : a_mem[bus.a_row][bus.a_col];
      if (bus.b_re) bus.b_rdata <= b_fwd ? b_wd : b_mem[bus.b_row][bus.b_col];
      if (bus.c_re) bus.c_rdata <= c_fwd ? c_wd : c_mem[bus.c_row][bus.c_col];
    end
  end

  // Stream loader. The counters walk the selected matrix in row-major order.
  // The last beat pulses ld_done and returns the loader to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state     <= L_IDLE;
      ld_sel_q     <= 1'b0;
      ld_row       <= '0;
      ld_col       <= '0;
      bus.ld_ready <= 1'b0;
      bus.ld_done  <= 1'b0;
    end else begin
      bus.ld_done <= 1'b0;
      case (ld_state)
        L_IDLE: begin
          if (bus.ld_start) begin
            ld_state     <= L_RUN;
            ld_sel_q     <= bus.ld_sel;
            ld_row       <= '0;
            ld_col       <= '0;
            bus.ld_ready <= 1'b1;
          end
        end
        L_RUN: begin
          if (ld_beat) begin
            if (ld_last) begin
              ld_state     <= L_IDLE;
              ld_row       <= '0;
              ld_col       <= '0;
              bus.ld_ready <= 1'b0;
              bus.ld_done  <= 1'b1;
            end else if (ld_col == ld_col_max) begin
              ld_col <= '0;
              ld_row <= ld_row + RW'(1);
            end else begin
              ld_col <= ld_col + CW'(1);
            end
          end
        end
        default: ld_state <= L_IDLE;
      endcase
    end
  end

  // Clear engine. It writes one zero per cycle across C, and clr_busy marks
  // every cycle that performs a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state    <= C_IDLE;
      clr_row      <= '0;
      clr_col      <= '0;
      bus.clr_busy <= 1'b0;
    end else begin
      case (clr_state)
        C_IDLE: begin
          if (bus.clr_start) begin
            clr_state    <= C_RUN;
            clr_row      <= '0;
            clr_col      <= '0;
            bus.clr_busy <= 1'b1;
          end
        end
        C_RUN: begin
          if (clr_last) begin
            clr_state    <= C_IDLE;
            clr_row      <= '0;
            clr_col      <= '0;
            bus.clr_busy <= 1'b0;
          end else if (clr_col == NW'(N - 1)) begin
            clr_col <= '0;
            clr_row <= clr_row + MW'(1);
          end else begin
            clr_col <= clr_col + NW'(1);
          end
        end
        default: clr_state <= C_IDLE;
      endcase
    end
  end

  // err is sticky. Any dropped write or ignored start sets it, and only
  // reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.err <= 1'b0;
    end else if ((bus.a_we && a_locked) || (bus.b_we && b_locked) ||
                 (bus.c_we && clr_run) || (bus.ld_start && ld_run) ||
                 (bus.clr_start && clr_run)) begin
      bus.err <= 1'b1;
    end
  end
endmodule

// File: doc/mac_stop_mem_stream.md
MAC_STOP_MEM_STREAM -- requirements
Module: mac_stop_mem_stream

Interface
REQ-001 SHALL have parameter M, default 4: rows of A and C.
REQ-002 SHALL have parameter K, default 4: columns of A and rows of B.
REQ-003 SHALL have parameter N, default 4: columns of B and C.
REQ-004 SHALL have parameter DATA_WIDTH_INIT_MATRIX (W), default 32: A/B element width.
REQ-005 SHALL have parameter DATA_WIDTH_RESULT_MATRIX (R), default 2*W+$clog2(K): C element width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have ports a_we/a_re (in, 1), a_row (in, clog2 M), a_col (in, clog2 K), a_wdata (in, W), a_rdata (out, W), a_rvalid (out, 1): random access to A.
REQ-009 SHALL have ports b_we/b_re (in, 1), b_row (in, clog2 K), b_col (in, clog2 N), b_wdata (in, W), b_rdata (out, W), b_rvalid (out, 1): random access to B.
REQ-010 SHALL have ports c_we/c_re/c_acc (in, 1), c_row (in, clog2 M), c_col (in, clog2 N), c_wdata (in, R), c_rdata (out, R), c_rvalid (out, 1): random access to C.
REQ-011 SHALL have ports ld_start (in, 1), ld_sel (in, 1; 0=A, 1=B), ld_valid (in, 1), ld_data (in, W), ld_ready (out, 1), ld_done (out, 1): stream loader.
REQ-012 SHALL have ports clr_start (in, 1) and clr_busy (out, 1): C clear engine.
REQ-013 SHALL have port err (out, 1): sticky conflict flag.

Function
REQ-014 SHALL perform random writes on the clock edge at the addressed element when *_we=1.
REQ-015 SHALL register reads: *_re=1 in cycle t gives *_rdata and *_rvalid=1 in cycle t+1; with *_re=0, *_rvalid=0 and *_rdata holds its last value.
REQ-016 SHALL, for same-cycle read and write of the same element, return the old value.
REQ-017 SHALL, when c_we=1 and c_acc=1, store old C element + c_wdata, modulo 2^R, with no saturation.
REQ-018 SHALL run the loader FSM in L_IDLE or L_RUN: in L_IDLE, ld_start moves it to L_RUN, latches ld_sel and zeroes the row/col counters.
REQ-019 SHALL, in L_RUN, assert ld_ready=1; each beat (ld_valid and ld_ready) writes ld_data at the counter address, and the counters advance row-major (col wraps at K for A or N for B, then row increments).
REQ-020 SHALL, on the final beat (A: M*K beats, B: K*N beats), pulse ld_done for one cycle, wrap the counters to 0 and return to L_IDLE; a zero-beat load is not possible.
REQ-021 SHALL run the clear FSM in C_IDLE or C_RUN: clr_start in C_IDLE enters C_RUN, which writes 0 to one C element per cycle row-major for M*N cycles with clr_busy=1, then returns to C_IDLE.
REQ-022 SHALL allow the loader and the clear engine to run concurrently.
REQ-023 SHALL, on a conflict, drop the random write, let the engine write win, and set err (sticky); conflicts are: a random write to the matrix being loaded during L_RUN, c_we during C_RUN, ld_start during L_RUN, and clr_start during C_RUN.
REQ-024 SHALL leave random reads always permitted and unaffected by the engines.

Reset
REQ-025 SHALL, on reset, zero all of A, B and C and all rdata, and clear rvalid, ld_ready, ld_done, clr_busy and err; both FSMs go to idle.
REQ-026 SHALL, on reset mid-load or mid-clear, abort the operation without asserting ld_done; reset overrides every other input.

Configuration
REQ-027 SHALL, with MAC_STOP_MEM_FWD_EN defined, forward write data on a same-cycle same-address read: the new value, or the accumulated sum when c_acc=1.
REQ-028 SHALL, without MAC_STOP_MEM_FWD_EN, follow REQ-016 and return the old value.

Verification (M=K=N=4, W=8, R=18)
REQ-029 SHALL cover: write A[1][2]=0x5A, then a_re at t -> a_rdata=0x5A and a_rvalid=1 at t+1.
REQ-030 SHALL cover: C[3][3]=0x3FFFF, then c_we+c_acc with c_wdata=2 -> read returns 0x00001.
REQ-031 SHALL cover: load B (ld_sel=1) with 16 beats 0..15 and ld_valid low every third cycle -> B[r][c]=4r+c and ld_done pulses once after beat 15.
REQ-032 SHALL cover: clr_start with C fully nonzero -> clr_busy high for 16 cycles, all C=0, err=0.
REQ-033 SHALL cover: a_we to A[0][0]=0x11 during an A load, and ld_start during L_RUN -> the loader data wins and err=1 until reset.
REQ-034 SHALL cover: reset after 5 load beats -> A all zero, FSM idle, no ld_done; same-address write+read gives 0x77 with FWD_EN and the old value without it.
